// File: rtl/enc8to3_pkg.sv
// Shared definitions for the 8-to-3 round-robin request encoder.
//   N        number of request lines (fixed at 8)
//   CW       code width, log2(N)
//   state_t  encoder FSM states: IDLE (nothing presented), PRESENT (W/Valid loaded)
//   onehot8  converts a 3-bit code to its one-hot 8-bit mask
package enc8to3_pkg;

    localparam int N  = 8;
    localparam int CW = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot8(input logic [CW-1:0] code);
        logic [N-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/enc8to3_rr_pick8.sv
// Combinational round-robin picker over an 8-bit mask.
// Ports:
//   mask   in   8  candidate bits
//   ptr    in   3  index where the search starts
//   idx    out  3  first set bit at or after ptr (wrapping), 0 when none
//   found  out  1  any bit of mask set
module rr_pick8
    import enc8to3_pkg::*;
(
    input  logic [N-1:0]  mask,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] idx,
    output logic          found
);

    logic [CW:0]   pos;
    logic [CW-1:0] cand;

    always_comb begin
        idx   = '0;
        found = |mask;
        pos   = '0;
        cand  = '0;
        // Walk from the farthest offset back to ptr so the nearest set bit
        // is the last one written. The sum is 4 bits wide and truncated,
        // which gives the modulo-8 wrap.
        for (int i = N - 1; i >= 0; i--) begin
            pos  = {1'b0, ptr} + 4'(i);
            cand = CW'(pos);
            if (mask[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/enc8to3_rr.sv
// Sequential 8-to-3 request encoder with round-robin service.
// Request strobes are OR-ed into a pending register while En is high and are
// presented one at a time as 3-bit codes over a Valid/Ready handshake.
// Ports:
//   Clock  in   1  rising-edge clock
//   Reset  in   1  synchronous active-high reset
//   En     in   1  capture enable for R
//   R      in   8  request strobes
//   Ready  in   1  consumer takes W when Valid is high
//   W      out  3  registered code of the presented request
//   Valid  out  1  registered, W holds a pending request
//   Busy   out  1  any request pending or presented
module enc8to3_rr
    import enc8to3_pkg::*;
(
    input  logic          Clock,
    input  logic          Reset,
    input  logic          En,
    input  logic [N-1:0]  R,
    input  logic          Ready,
    output logic [CW-1:0] W,
    output logic          Valid,
    output logic          Busy
);

    logic [N-1:0]  pend;
    logic [CW-1:0] ptr;
    state_t        state;

    logic [N-1:0]  cap;
    logic [N-1:0]  w_hot;
    logic          handshake;
    logic [N-1:0]  pick_mask;
    logic [CW-1:0] pick_ptr;
    logic [CW-1:0] pick_idx;
    logic          pick_found;

    assign cap       = En ? R : '0;
    assign w_hot     = onehot8(W);
    assign handshake = (state == PRESENT) && Ready;

    // One picker serves both cases: in IDLE it scans the pending bits from
    // the stored pointer; while presenting it scans what remains once the
    // current code is retired, starting just past that code. Requests
    // captured this cycle are not in pend yet, so they cannot be re-picked.
    always_comb begin
        pick_mask = pend;
        pick_ptr  = ptr;
        if (state == PRESENT) begin
            pick_mask = pend & ~w_hot;
            pick_ptr  = W + 3'd1;
        end
    end

    rr_pick8 u_pick (
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend  <= '0;
            ptr   <= '0;
            state <= IDLE;
            W     <= '0;
            Valid <= 1'b0;
        end else begin
            // A new strobe on the retiring line re-queues it (set wins).
            if (handshake) begin
                pend <= (pend & ~w_hot) | cap;
            end else begin
                pend <= pend | cap;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        W     <= pick_idx;
                        Valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (Ready) begin
                        ptr <= W + 3'd1;
                        if (pick_found) begin
                            W <= pick_idx;
                        end else begin
                            Valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Busy = (|pend) | Valid;

endmodule

// File: tb/tb_enc8to3_rr.sv
// Testbench for enc8to3_rr: directed vector table with explicit expected
// outputs, plus randomized traffic compared against a behavioural model.
module tb_enc8to3_rr;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       En;
    logic [7:0] R;
    logic       Ready;
    logic [2:0] W;
    logic       Valid;
    logic       Busy;

    always #5 Clock = ~Clock;

    enc8to3_rr dut (
        .Clock (Clock),
        .Reset (Reset),
        .En    (En),
        .R     (R),
        .Ready (Ready),
        .W     (W),
        .Valid (Valid),
        .Busy  (Busy)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: pending set, pointer and presented code as plain values.
    bit [7:0] m_p;
    int       m_ptr;
    int       m_w;
    bit       m_valid;

    typedef struct {
        bit       rst;
        bit       en;
        bit [7:0] r;
        bit       rdy;
        int       w;
        bit       v;
        bit       b;
    } vec_t;

    vec_t vecs[$];

    function automatic int rr_first(bit [7:0] mask, int start);
        for (int k = 0; k < 8; k++) begin
            if (mask[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(bit rst, bit en, bit [7:0] r, bit rdy);
        bit [7:0] cap;
        int       nxt;
        if (rst) begin
            m_p = '0; m_ptr = 0; m_w = 0; m_valid = 1'b0;
            return;
        end
        cap = en ? r : 8'h00;
        if (!m_valid) begin
            nxt = rr_first(m_p, m_ptr);
            if (nxt >= 0) begin
                m_w = nxt;
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            m_p[m_w] = 1'b0;
            m_ptr = (m_w + 1) % 8;
            nxt = rr_first(m_p, m_ptr);
            if (nxt >= 0) m_w = nxt;
            else m_valid = 1'b0;
        end
        m_p = m_p | cap;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(bit rst, bit en, bit [7:0] r, bit rdy);
        Reset = rst; En = en; R = r; Ready = rdy;
        @(posedge Clock);
        model_step(rst, en, r, rdy);
        #1;
        check("model_W", int'(W), m_w);
        check("model_Valid", int'(Valid), int'(m_valid));
        check("model_Busy", int'(Busy), int'((m_p != 0) || m_valid));
    endtask

    task automatic add(bit rst, bit en, bit [7:0] r, bit rdy, int w, bit v, bit b);
        vec_t t;
        t.rst = rst; t.en = en; t.r = r; t.rdy = rdy; t.w = w; t.v = v; t.b = b;
        vecs.push_back(t);
    endtask

    initial begin
        Reset = 1'b1; En = 1'b0; R = '0; Ready = 1'b0;
        m_p = '0; m_ptr = 0; m_w = 0; m_valid = 1'b0;

        // rst en  R      rdy  W  V  B   (outputs after the edge)
        add(1, 0, 8'h00, 0,   0, 0, 0);
        // single request, latency two edges, one-cycle Valid
        add(0, 1, 8'h04, 1,   0, 0, 1);
        add(0, 1, 8'h00, 1,   2, 1, 1);
        add(0, 1, 8'h00, 1,   2, 0, 0);
        // two ends of the ring back to back, pointer wraps to 0
        add(1, 0, 8'h00, 0,   0, 0, 0);
        add(0, 1, 8'h81, 1,   0, 0, 1);
        add(0, 1, 8'h00, 1,   0, 1, 1);
        add(0, 1, 8'h00, 1,   7, 1, 1);
        add(0, 1, 8'h00, 1,   7, 0, 0);
        add(0, 1, 8'h81, 1,   7, 0, 1);
        add(0, 1, 8'h00, 1,   0, 1, 1);
        add(0, 1, 8'h00, 1,   7, 1, 1);
        add(0, 1, 8'h00, 1,   7, 0, 0);
        // backpressure: W=3 held while a new request arrives
        add(0, 1, 8'h08, 0,   7, 0, 1);
        add(0, 1, 8'h00, 0,   3, 1, 1);
        add(0, 1, 8'h20, 0,   3, 1, 1);
        add(0, 1, 8'h00, 0,   3, 1, 1);
        add(0, 1, 8'h00, 0,   3, 1, 1);
        add(0, 1, 8'h00, 0,   3, 1, 1);
        add(0, 1, 8'h00, 1,   5, 1, 1);
        add(0, 1, 8'h00, 1,   5, 0, 0);
        // re-request on the retiring line is re-queued behind 5
        add(1, 0, 8'h00, 0,   0, 0, 0);
        add(0, 1, 8'h31, 1,   0, 0, 1);
        add(0, 1, 8'h00, 1,   0, 1, 1);
        add(0, 1, 8'h00, 1,   4, 1, 1);
        add(0, 1, 8'h10, 1,   5, 1, 1);
        add(0, 1, 8'h00, 1,   4, 1, 1);
        add(0, 1, 8'h00, 1,   4, 0, 0);
        // En=0 ignores requests, then all eight drain in order
        add(1, 0, 8'h00, 0,   0, 0, 0);
        add(0, 0, 8'hFF, 1,   0, 0, 0);
        add(0, 0, 8'hFF, 1,   0, 0, 0);
        add(0, 0, 8'hFF, 1,   0, 0, 0);
        add(0, 1, 8'hFF, 1,   0, 0, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 8'hFF, 1, i, 1, 1);
        add(0, 0, 8'h00, 1,   7, 0, 0);
        // reset during a drain discards everything
        add(0, 1, 8'h60, 0,   7, 0, 1);
        add(0, 1, 8'h00, 0,   5, 1, 1);
        add(1, 1, 8'h00, 1,   0, 0, 0);
        add(0, 1, 8'h00, 1,   0, 0, 0);
        add(0, 1, 8'h00, 1,   0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].r, vecs[i].rdy);
            check($sformatf("vec%0d_W", i), int'(W), vecs[i].w);
            check($sformatf("vec%0d_Valid", i), int'(Valid), int'(vecs[i].v));
            check($sformatf("vec%0d_Busy", i), int'(Busy), int'(vecs[i].b));
        end

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            bit       rr_rst;
            bit       rr_en;
            bit [7:0] rr_r;
            bit       rr_rdy;
            rr_rst = ($urandom_range(0, 79) == 0);
            rr_en  = ($urandom_range(0, 3) != 0);
            rr_r   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rr_rdy = ($urandom_range(0, 3) != 0);
            step(rr_rst, rr_en, rr_r, rr_rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enc8to3_rr.md
# enc8to3_rr

Sequential 8-to-3 request encoder: captures one-hot or multi-hot request strobes into a pending register and emits them one at a time as 3-bit binary codes over a valid/ready handshake. Pending requests are served in round-robin order. The block is the encoding end of the 3-bit code path driven into the lab's 3-to-8 enable decoders. A producer raises request lines, and the consumer takes codes and drives them into a decoder's W input.

## Interface
- N, 8, number of request lines. Fixed at 8 for this lab; other values are unsupported.
- CW, 3, code width, equal to log2(N).
- Clock  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  capture enable. When 0, R is ignored; already-pending requests still drain.
- R  input  N  request strobes, sampled every edge while En=1.
- Ready  input  1  consumer accepts W this cycle when Valid=1.
- W  output  CW  encoded index of the presented request.
- Valid  output  1  W holds a pending request.
- Busy  output  1  high when any request is pending or presented (|P or Valid).

## Operation
- Internal state:
  - P[7:0]: pending bits.
  - Ptr[2:0]: round-robin start index.
  - FSM with states IDLE and PRESENT.
- Reset (Reset=1 at an edge):
  - P=0, Ptr=0, state=IDLE, W=3'b000, Valid=0, Busy=0.
  - Reset wins over every other event, including a handshake in the same cycle.
  - Reset discards any presented or pending request.
- Capture: at each edge with En=1, P |= R.
- Pick: the search runs over the mask in order Ptr, Ptr+1, …, Ptr+7 (mod 8). The first set bit gives idx; found = |mask.
- IDLE:
  - Mask = P.
  - If found: W<=idx, Valid<=1, go to PRESENT.
  - Otherwise stay in IDLE.
- PRESENT with Ready=0:
  - W and Valid hold unchanged.
  - The presented bit P[W] stays set.
- PRESENT with Ready=1 (handshake):
  - Clear P[W], unless R[W]=1 with En=1 in the same cycle. Set wins and the request is re-queued.
  - Ptr <= W+1 mod 8 (7 wraps to 0).
  - Re-pick over mask = P & ~onehot(W), using the updated pointer.
  - If found: W<=idx, Valid stays 1, stay in PRESENT. Back-to-back codes have no bubble.
  - Otherwise: Valid<=0, W holds its last value, go to IDLE.
- Requests arriving in the handshake cycle are not eligible for that re-pick. They become eligible at the next edge.
- Duplicate requests: R[i] while P[i]=1 does not stack. Each pending bit is served once.
- Width rules:
  - Ptr and W additions are 3-bit modulo-8.
  - The search index is computed in 4 bits and truncated.

## Timing
- Latency from idle: R[i]=1 in cycle k gives Valid=1 with W=i in cycle k+2. P is set at edge k, and W/Valid load at edge k+1.
- Throughput: one code per cycle while Ready=1 and P is non-empty.
- Outputs W and Valid are registered. No combinational path exists from R or Ready to W or Valid.
- Busy = (|P) | Valid, decoded combinationally from registers only.
- W stays stable for as long as Valid=1 and Ready=0.

## Structure
- Shared package (enc8to3_pkg):
  - state enum {IDLE, PRESENT}.
  - Constants N=8 and CW=3.
  - Function onehot8(code).
- Sub-module rr_pick8 (combinational):
  - Inputs: mask[7:0], ptr[2:0].
  - Outputs: idx[2:0], found.
  - Instantiated once for the re-pick. The IDLE pick reuses it with mask=P.
- Top level holds P, Ptr, the FSM and the output registers.

## Test plan
- Reset, then R=8'b0000_0100 for one cycle, Ready=1. Expect Valid=1 with W=3'd2 in cycle k+2 for exactly one cycle, then Valid=0 and Busy=0.
- R=8'b1000_0001 in one cycle with Ptr=0, Ready=1. Expect W=0, then W=7 on consecutive cycles, then Valid=0. Expect Ptr=0 afterwards (7+1 wraps to 0).
- Hold Ready=0 for 5 cycles with W=3 presented while R=8'b0010_0000 arrives. Expect W=3 and Valid=1 stable throughout. After Ready=1, expect W=5 on the next cycle.
- Simultaneous events: handshake on W=4 while R[4]=1 and En=1 in the same cycle. Expect P[4] to remain set and 4 to be presented again after the other pending bits in round-robin order.
- En=0 with R=8'hFF for 3 cycles. Expect P=0, Valid=0, Busy=0. Then En=1 for one cycle with R=8'hFF and Ready=1. Expect codes 0..7 in order on 8 consecutive cycles.
- Reset asserted mid-drain with P=8'b0110_0000 and Valid=1. After that edge, expect Valid=0, W=0, Busy=0, and no further codes.
